// File: rtl/upc_serial_tx.sv
// rtl/upc_serial_tx.sv - serial transmitter for 4-bit UPC codes with even parity
//
// Frame on TX: start(0), M, U, P, C, parity, stop(1). Each bit lasts BAUD_DIV clocks.
//
// Parameters:
//   BAUD_DIV  clock cycles per serial bit, legal range 1..16
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous active-high reset
//   UPC    in   4  code to send, {M,U,P,C}
//   valid  in   1  UPC holds a code to send
//   ready  out  1  block accepts a code on this edge (valid & ready)
//   TX     out  1  serial line, idles high
//   busy   out  1  a frame is in progress
//   done   out  1  one-cycle pulse in the final cycle of the stop bit
module upc_serial_tx #(
  parameter int BAUD_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] UPC,
  input  logic       valid,
  output logic       ready,
  output logic       TX,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Baud counter value of the last cycle of a bit.
  localparam logic [3:0] LAST = 4'(BAUD_DIV - 1);

  state_t     state;
  logic [3:0] baud_cnt;
  logic [1:0] bit_idx;
  logic [3:0] upc_q;

  logic       bit_end;
  logic [1:0] next_idx;

  assign bit_end  = (baud_cnt == LAST);
  assign next_idx = bit_idx + 2'd1;

  // All outputs are registers loaded with the value that belongs to the
  // state being entered, so they never see UPC/valid combinationally and
  // the asynchronous reset forces them to their reset values at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      upc_q    <= '0;
      TX       <= 1'b1;
      ready    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (valid && ready) begin
            upc_q <= UPC;
            state <= START;
            TX    <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            // Also raises ready on the first edge after reset release.
            TX    <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            TX       <= upc_q[3];
          end else begin
            baud_cnt <= baud_cnt + 4'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 2'd3) begin
              state <= PARITY;
              TX    <= ^upc_q;
            end else begin
              // MSB first: bit index 0..3 selects upc_q[3..0].
              bit_idx <= next_idx;
              TX      <= upc_q[2'd3 - next_idx];
            end
          end else begin
            baud_cnt <= baud_cnt + 4'd1;
          end
        end

        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= STOP;
            TX       <= 1'b1;
            // With a one-cycle bit the first stop cycle is also the last.
            done     <= (LAST == 4'd0);
          end else begin
            baud_cnt <= baud_cnt + 4'd1;
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
            TX       <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + 4'd1;
            done     <= ((baud_cnt + 4'd1) == LAST);
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
          TX       <= 1'b1;
          ready    <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upc_serial_tx.sv
// tb/tb_upc_serial_tx.sv - randomized self-checking bench for upc_serial_tx
module tb_upc_serial_tx;

  logic       clk;
  logic       reset;
  logic [3:0] upc4, upc1;
  logic       valid4, valid1;
  logic       ready4, ready1;
  logic       tx4, tx1;
  logic       busy4, busy1;
  logic       done4, done1;

  int n_checks;
  int n_pass;

  upc_serial_tx #(.BAUD_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .UPC(upc4), .valid(valid4),
    .ready(ready4), .TX(tx4), .busy(busy4), .done(done4)
  );

  upc_serial_tx #(.BAUD_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .UPC(upc1), .valid(valid1),
    .ready(ready1), .TX(tx1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic get_tx(int bd);    return (bd == 1) ? tx1 : tx4;       endfunction
  function automatic logic get_ready(int bd); return (bd == 1) ? ready1 : ready4; endfunction
  function automatic logic get_busy(int bd);  return (bd == 1) ? busy1 : busy4;   endfunction
  function automatic logic get_done(int bd);  return (bd == 1) ? done1 : done4;   endfunction

  task automatic drive(int bd, logic v, logic [3:0] u);
    if (bd == 1) begin valid1 = v; upc1 = u; end
    else begin valid4 = v; upc4 = u; end
  endtask

  // Reference: the 7 frame bits, parity from the count of ones.
  function automatic logic frame_bit(logic [3:0] code, int k);
    int ones;
    ones = $countones(code);
    case (k)
      0: return 1'b0;
      1: return code[3];
      2: return code[2];
      3: return code[1];
      4: return code[0];
      5: return logic'(ones % 2);
      default: return 1'b1;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(int bd);
    for (int i = 0; i < 64 && !get_ready(bd); i++) step();
    check($sformatf("wait_ready bd=%0d", bd), get_ready(bd), 1);
  endtask

  // Called at posedge+1 with ready=1: the next edge accepts 'code'.
  // With hold=1, valid stays high carrying hold_code during the frame.
  task automatic do_frame(int bd, logic [3:0] code, bit hold, logic [3:0] hold_code);
    int len;
    len = 7 * bd;
    drive(bd, 1'b1, code);
    step();
    if (hold) drive(bd, 1'b1, hold_code);
    else drive(bd, 1'b0, 4'($urandom));
    for (int c = 1; c <= len; c++) begin
      check($sformatf("tx bd=%0d code=%b cyc=%0d", bd, code, c), get_tx(bd), frame_bit(code, (c - 1) / bd));
      check($sformatf("busy bd=%0d cyc=%0d", bd, c), get_busy(bd), 1);
      check($sformatf("ready bd=%0d cyc=%0d", bd, c), get_ready(bd), 0);
      check($sformatf("done bd=%0d cyc=%0d", bd, c), get_done(bd), (c == len) ? 1 : 0);
      if (c < len) step();
    end
    step();
    check($sformatf("idle ready bd=%0d", bd), get_ready(bd), 1);
    check($sformatf("idle tx bd=%0d", bd), get_tx(bd), 1);
    check($sformatf("idle busy bd=%0d", bd), get_busy(bd), 0);
    check($sformatf("idle done bd=%0d", bd), get_done(bd), 0);
  endtask

  task automatic check_idle_all(string tag);
    check({tag, " tx4"}, tx4, 1);
    check({tag, " busy4"}, busy4, 0);
    check({tag, " done4"}, done4, 0);
    check({tag, " tx1"}, tx1, 1);
    check({tag, " busy1"}, busy1, 0);
    check({tag, " done1"}, done1, 0);
  endtask

  initial begin
    int bd;
    logic [3:0] code;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    valid4 = 1'b0; valid1 = 1'b0;
    upc4 = 4'd0; upc1 = 4'd0;

    #3;
    check_idle_all("reset");
    check("reset ready4", ready4, 0);
    check("reset ready1", ready1, 0);
    step();
    step();
    reset = 1'b0;
    step();
    check("post-reset ready4", ready4, 1);
    check("post-reset ready1", ready1, 1);

    // Quiet line while valid stays low.
    for (int i = 0; i < 50; i++) begin
      check_idle_all($sformatf("quiet %0d", i));
      step();
    end

    do_frame(4, 4'b1010, 1'b0, 4'd0);
    do_frame(4, 4'b0111, 1'b0, 4'd0);
    do_frame(1, 4'b1111, 1'b0, 4'd0);

    // Held valid with new code: second frame starts right after the idle cycle.
    do_frame(4, 4'b1100, 1'b1, 4'b0011);
    do_frame(4, 4'b0011, 1'b0, 4'd0);

    // Reset in cycle 10 of a frame.
    drive(4, 1'b1, 4'b1011);
    step();
    drive(4, 1'b0, 4'b0000);
    for (int c = 1; c < 10; c++) step();
    check("pre-abort busy", busy4, 1);
    #2;
    reset = 1'b1;
    #1;
    check("abort tx", tx4, 1);
    check("abort busy", busy4, 0);
    check("abort ready", ready4, 0);
    check("abort done", done4, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("in-reset done", done4, 0);
      check("in-reset tx", tx4, 1);
    end
    reset = 1'b0;
    step();
    check("release ready4", ready4, 1);
    check("release tx4", tx4, 1);
    do_frame(4, 4'b0001, 1'b0, 4'd0);

    // Randomized frames on both instances.
    for (int i = 0; i < 24; i++) begin
      bd   = ($urandom_range(0, 1) == 0) ? 1 : 4;
      code = 4'($urandom);
      for (int g = $urandom_range(0, 3); g > 0; g--) step();
      wait_ready(bd);
      do_frame(bd, code, 1'($urandom_range(0, 1)), 4'($urandom));
      drive(bd, 1'b0, 4'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
